// File: rtl/tm_pkg.sv
// Shared definitions for the parenthesis-checking tape machine: controller
// states, default tape symbols and a state-classification helper.
package tm_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SCAN_R    = 3'd1,
        SCAN_L    = 3'd2,
        CHECK_L   = 3'd3,
        WRITE_RES = 3'd4,
        HALT      = 3'd5
    } tm_state_e;

    localparam logic [7:0] TM_SYM_BLANK = 8'h00;
    localparam logic [7:0] TM_SYM_OPEN  = 8'h28;
    localparam logic [7:0] TM_SYM_CLOSE = 8'h29;
    localparam logic [7:0] TM_SYM_MARK  = 8'h58;
    localparam logic [7:0] TM_SYM_TRUE  = 8'h54;
    localparam logic [7:0] TM_SYM_FALSE = 8'h46;

    // States in which every cycle consumes one step of the budget.
    function automatic logic is_step_state(input tm_state_e s);
        return (s == SCAN_R) || (s == SCAN_L) || (s == CHECK_L);
    endfunction

endpackage

// File: rtl/tm_paren_checker.sv
// Turing-machine controller that marks matched parenthesis pairs on an external
// tape, then writes 'T' or 'F' into cell 0 and halts.
module tm_paren_checker
    import tm_pkg::*;
#(
    parameter int               SYM_W     = 8,
    parameter int               ADDR_W    = 8,
    parameter int               STEP_W    = 16,
    parameter int               MAX_STEPS = 60000,
    parameter logic [SYM_W-1:0] SYM_BLANK = TM_SYM_BLANK,
    parameter logic [SYM_W-1:0] SYM_OPEN  = TM_SYM_OPEN,
    parameter logic [SYM_W-1:0] SYM_CLOSE = TM_SYM_CLOSE,
    parameter logic [SYM_W-1:0] SYM_MARK  = TM_SYM_MARK,
    parameter logic [SYM_W-1:0] SYM_TRUE  = TM_SYM_TRUE,
    parameter logic [SYM_W-1:0] SYM_FALSE = TM_SYM_FALSE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] tape_addr,
    input  logic [SYM_W-1:0]  tape_rdata,
    output logic [SYM_W-1:0]  tape_wdata,
    output logic              tape_we,
    output logic              busy,
    output logic              halt,
    output logic              accept,
    output logic              timeout,
    output logic [STEP_W-1:0] steps
);

    localparam logic [ADDR_W-1:0] POS_ZERO   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] POS_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] POS_LAST   = {ADDR_W{1'b1}};
    localparam logic [STEP_W-1:0] STEP_ZERO  = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE   = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

    tm_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              accept_q, accept_d;
    logic              timeout_q, timeout_d;
    logic              we_s;
    logic [SYM_W-1:0]  wdata_s;
    logic              decide_s;
    logic              verdict_s;

    // State register; reset aborts a run without writing any result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pos_q     <= POS_ZERO;
            steps_q   <= STEP_ZERO;
            accept_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            steps_q   <= steps_d;
            accept_q  <= accept_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and Mealy tape-write logic.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        steps_d   = steps_q;
        accept_d  = accept_q;
        timeout_d = timeout_q;
        we_s      = 1'b0;
        wdata_s   = SYM_BLANK;
        decide_s  = 1'b0;
        verdict_s = 1'b0;

        if (is_step_state(state_q)) begin
            if (steps_q == STEP_LIMIT) begin
                state_d   = WRITE_RES;
                accept_d  = 1'b0;
                timeout_d = 1'b1;
                pos_d     = POS_ZERO;
            end else begin
                steps_d = steps_q + STEP_ONE;
                case (state_q)
                    SCAN_R: begin
                        if ((tape_rdata == SYM_OPEN) || (tape_rdata == SYM_MARK)) begin
                            if (pos_q == POS_LAST) begin
                                decide_s = 1'b1;
                            end else begin
                                pos_d = pos_q + POS_ONE;
                            end
                        end else if (tape_rdata == SYM_CLOSE) begin
                            we_s    = 1'b1;
                            wdata_s = SYM_MARK;
                            if (pos_q == POS_ZERO) begin
                                decide_s = 1'b1;
                            end else begin
                                pos_d   = pos_q - POS_ONE;
                                state_d = SCAN_L;
                            end
                        end else if (tape_rdata == SYM_BLANK) begin
                            if (pos_q == POS_ZERO) begin
                                decide_s  = 1'b1;
                                verdict_s = 1'b1;
                            end else begin
                                pos_d   = pos_q - POS_ONE;
                                state_d = CHECK_L;
                            end
                        end else begin
                            decide_s = 1'b1;
                        end
                    end
                    SCAN_L: begin
                        if (tape_rdata == SYM_OPEN) begin
                            we_s    = 1'b1;
                            wdata_s = SYM_MARK;
                            pos_d   = pos_q + POS_ONE;
                            state_d = SCAN_R;
                        end else if ((tape_rdata == SYM_MARK) && (pos_q != POS_ZERO)) begin
                            pos_d = pos_q - POS_ONE;
                        end else begin
                            decide_s = 1'b1;
                        end
                    end
                    CHECK_L: begin
                        if (tape_rdata == SYM_MARK) begin
                            if (pos_q == POS_ZERO) begin
                                decide_s  = 1'b1;
                                verdict_s = 1'b1;
                            end else begin
                                pos_d = pos_q - POS_ONE;
                            end
                        end else begin
                            decide_s = 1'b1;
                        end
                    end
                    default: begin
                        decide_s = 1'b1;
                    end
                endcase
                // Parking pos at 0 makes WRITE_RES address cell 0 with no extra mux.
                if (decide_s) begin
                    state_d  = WRITE_RES;
                    accept_d = verdict_s;
                    pos_d    = POS_ZERO;
                end else begin
                    accept_d = accept_q;
                end
            end
        end else begin
            case (state_q)
                IDLE, HALT: begin
                    if (start) begin
                        state_d   = SCAN_R;
                        pos_d     = POS_ZERO;
                        steps_d   = STEP_ZERO;
                        accept_d  = 1'b0;
                        timeout_d = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                WRITE_RES: begin
                    we_s    = 1'b1;
                    wdata_s = accept_q ? SYM_TRUE : SYM_FALSE;
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign tape_addr  = pos_q;
    assign tape_we    = we_s;
    assign tape_wdata = wdata_s;
    assign busy       = is_step_state(state_q) || (state_q == WRITE_RES);
    assign halt       = (state_q == HALT);
    assign accept     = accept_q;
    assign timeout    = timeout_q;
    assign steps      = steps_q;

endmodule

// File: tb/tb_tm_paren_checker.sv
// Directed bench: three checker instances (default, 4-step budget, 4-cell tape)
// each attached to its own behavioural tape RAM.
module tb_tm_paren_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic load_a = 1'b0, load_b = 1'b0, load_c = 1'b0;
    logic [7:0] init [256];
    int total = 0;
    int bad = 0;

    logic [7:0]  addr_a, rdata_a, wdata_a, addr_b, rdata_b, wdata_b;
    logic [1:0]  addr_c;
    logic [7:0]  rdata_c, wdata_c;
    logic        we_a, busy_a, halt_a, acc_a, to_a;
    logic        we_b, busy_b, halt_b, acc_b, to_b;
    logic        we_c, busy_c, halt_c, acc_c, to_c;
    logic [15:0] steps_a, steps_b, steps_c;
    logic [7:0]  mem_a [256];
    logic [7:0]  mem_b [256];
    logic [7:0]  mem_c [4];

    always #5 clk = ~clk;

    tm_paren_checker dut_a (
        .clk(clk), .reset(reset), .start(start_a), .tape_addr(addr_a), .tape_rdata(rdata_a),
        .tape_wdata(wdata_a), .tape_we(we_a), .busy(busy_a), .halt(halt_a),
        .accept(acc_a), .timeout(to_a), .steps(steps_a));

    tm_paren_checker #(.MAX_STEPS(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .tape_addr(addr_b), .tape_rdata(rdata_b),
        .tape_wdata(wdata_b), .tape_we(we_b), .busy(busy_b), .halt(halt_b),
        .accept(acc_b), .timeout(to_b), .steps(steps_b));

    tm_paren_checker #(.ADDR_W(2)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .tape_addr(addr_c), .tape_rdata(rdata_c),
        .tape_wdata(wdata_c), .tape_we(we_c), .busy(busy_c), .halt(halt_c),
        .accept(acc_c), .timeout(to_c), .steps(steps_c));

    always @(posedge clk) begin
        if (load_a) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init[i];
        end else if (we_a) begin
            mem_a[addr_a] <= wdata_a;
        end
    end
    always @(posedge clk) begin
        if (load_b) begin
            for (int j = 0; j < 256; j++) mem_b[j] <= init[j];
        end else if (we_b) begin
            mem_b[addr_b] <= wdata_b;
        end
    end
    always @(posedge clk) begin
        if (load_c) begin
            for (int k = 0; k < 4; k++) mem_c[k] <= init[k];
        end else if (we_c) begin
            mem_c[addr_c] <= wdata_c;
        end
    end
    assign rdata_a = mem_a[addr_a];
    assign rdata_b = mem_b[addr_b];
    assign rdata_c = mem_c[addr_c];

    // Byte 0 of v is cell 0; remaining cells are blank.
    task automatic load_tape(input int w, input logic [63:0] v);
        for (int i = 0; i < 256; i++) init[i] = 8'h00;
        for (int i = 0; i < 8; i++) init[i] = v[8*i +: 8];
        @(negedge clk);
        if (w == 0) load_a = 1'b1; else if (w == 1) load_b = 1'b1; else load_c = 1'b1;
        @(negedge clk);
        load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    endtask

    function automatic logic halt_of(input int w);
        return (w == 0) ? halt_a : (w == 1) ? halt_b : halt_c;
    endfunction

    // Pulse start, count edges until halt is seen; extra_at re-pulses start mid-run.
    task automatic run(input int w, input int extra_at, output int cyc);
        cyc = 0;
        if (w == 0) start_a = 1'b1; else if (w == 1) start_b = 1'b1; else start_c = 1'b1;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            start_a = (w == 0) && (cyc == extra_at);
            start_b = 1'b0;
            start_c = 1'b0;
            if (halt_of(w)) break;
        end
        start_a = 1'b0;
        total++;
        if (!halt_of(w)) begin
            bad++;
            $display("FAIL halt_wait inst=%0d: halt never rose within %0d cycles", w, cyc);
        end
    endtask

    task automatic check_idle_a(input string tag);
        total++;
        if ({busy_a, halt_a, acc_a, to_a, we_a} !== 5'b00000 || steps_a !== 16'd0 || addr_a !== 8'd0) begin
            bad++;
            $display("FAIL %s: busy=%b halt=%b acc=%b to=%b we=%b steps=%0d addr=%0d, required all 0",
                     tag, busy_a, halt_a, acc_a, to_a, we_a, steps_a, addr_a);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_a("reset_state");
    endtask

    task automatic test_simple_pair();
        int cyc;
        load_tape(0, 64'h2928);
        run(0, 0, cyc);
        total++;
        if (cyc !== 9) begin bad++; $display("FAIL pair_latency: got %0d edges, required 9", cyc); end
        total++;
        if (acc_a !== 1'b1 || to_a !== 1'b0 || steps_a !== 16'd7 || busy_a !== 1'b0) begin
            bad++; $display("FAIL pair_result: acc=%b to=%b steps=%0d busy=%b, required 1 0 7 0", acc_a, to_a, steps_a, busy_a);
        end
        total++;
        if (mem_a[0] !== 8'h54 || mem_a[1] !== 8'h58 || mem_a[2] !== 8'h00) begin
            bad++; $display("FAIL pair_tape: got %h %h %h, required 54 58 00", mem_a[0], mem_a[1], mem_a[2]);
        end
    endtask

    task automatic test_reject_first();
        int cyc;
        load_tape(0, 64'h2829);
        run(0, 0, cyc);
        total++;
        if (acc_a !== 1'b0 || steps_a !== 16'd1 || mem_a[0] !== 8'h46 || to_a !== 1'b0) begin
            bad++; $display("FAIL close_first: acc=%b steps=%0d cell0=%h to=%b, required 0 1 46 0", acc_a, steps_a, mem_a[0], to_a);
        end
    endtask

    task automatic test_check_left();
        int cyc;
        load_tape(0, 64'h292828);
        run(0, 0, cyc);
        total++;
        if (acc_a !== 1'b0 || mem_a[0] !== 8'h46) begin
            bad++; $display("FAIL unmatched_open: acc=%b cell0=%h, required 0 46", acc_a, mem_a[0]);
        end
    endtask

    task automatic test_nested();
        int cyc;
        load_tape(0, 64'h292829292828);
        run(0, 0, cyc);
        total++;
        if (acc_a !== 1'b1 || mem_a[0] !== 8'h54 || mem_a[3] !== 8'h58 || mem_a[5] !== 8'h58 || mem_a[6] !== 8'h00) begin
            bad++; $display("FAIL nested: acc=%b cells %h %h %h %h, required 1 54 58 58 00", acc_a, mem_a[0], mem_a[3], mem_a[5], mem_a[6]);
        end
    endtask

    task automatic test_empty();
        int cyc;
        load_tape(0, 64'h0);
        run(0, 0, cyc);
        total++;
        if (acc_a !== 1'b1 || steps_a !== 16'd1 || mem_a[0] !== 8'h54) begin
            bad++; $display("FAIL empty: acc=%b steps=%0d cell0=%h, required 1 1 54", acc_a, steps_a, mem_a[0]);
        end
    endtask

    task automatic test_bad_symbol();
        int cyc;
        load_tape(0, 64'h4128);
        run(0, 0, cyc);
        total++;
        if (acc_a !== 1'b0 || steps_a !== 16'd2 || mem_a[0] !== 8'h46) begin
            bad++; $display("FAIL bad_symbol: acc=%b steps=%0d cell0=%h, required 0 2 46", acc_a, steps_a, mem_a[0]);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        load_tape(1, 64'h2928);
        run(1, 0, cyc);
        total++;
        if (to_b !== 1'b1 || acc_b !== 1'b0 || steps_b !== 16'd4 || mem_b[0] !== 8'h46) begin
            bad++; $display("FAIL timeout: to=%b acc=%b steps=%0d cell0=%h, required 1 0 4 46", to_b, acc_b, steps_b, mem_b[0]);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        load_tape(2, 64'h28282828);
        run(2, 0, cyc);
        total++;
        if (acc_c !== 1'b0 || to_c !== 1'b0 || steps_c !== 16'd4 || mem_c[0] !== 8'h46) begin
            bad++; $display("FAIL overflow: acc=%b to=%b steps=%0d cell0=%h, required 0 0 4 46", acc_c, to_c, steps_c, mem_c[0]);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        load_tape(0, 64'h2928);
        run(0, 3, cyc);
        total++;
        if (cyc !== 9 || steps_a !== 16'd7 || acc_a !== 1'b1) begin
            bad++; $display("FAIL busy_start: edges=%0d steps=%0d acc=%b, required 9 7 1", cyc, steps_a, acc_a);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        load_tape(0, 64'h292829292828);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_a("reset_mid_run");
        total++;
        if (mem_a[0] !== 8'h28 || mem_a[2] !== 8'h58) begin
            bad++; $display("FAIL reset_tape: cell0=%h cell2=%h, required 28 58", mem_a[0], mem_a[2]);
        end
        load_tape(0, 64'h2928);
        run(0, 0, cyc);
        total++;
        if (acc_a !== 1'b1 || steps_a !== 16'd7 || mem_a[0] !== 8'h54) begin
            bad++; $display("FAIL rerun: acc=%b steps=%0d cell0=%h, required 1 7 54", acc_a, steps_a, mem_a[0]);
        end
    endtask

    initial begin
        test_reset();
        test_simple_pair();
        test_reject_first();
        test_check_left();
        test_nested();
        test_empty();
        test_bad_symbol();
        test_timeout();
        test_overflow();
        test_start_while_busy();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
